// File: rtl/trace_trigger.sv
// Trace trigger: masked event matcher that arms, counts qualifying matches, captures a
// post-trigger window and pulses trigger on the final stored event. Optional arm timeout: TRACE_TRIGGER_TIMEOUT_EN.
module trace_trigger #(
  parameter int DATA_WIDTH         = 32,
  parameter int MATCH_OCCURRENCE   = 1,
  parameter int POST_TRIGGER_COUNT = 16,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  event_valid,
  input  logic [DATA_WIDTH-1:0] event_data,
  input  logic [DATA_WIDTH-1:0] match_value,
  input  logic [DATA_WIDTH-1:0] match_mask,
  output logic [DATA_WIDTH-1:0] capture_data,
  output logic                  capture_enable,
  output logic                  trigger,
  output logic                  armed,
  output logic                  done
);

  localparam int MW = $clog2(MATCH_OCCURRENCE + 1);
  localparam int PW = (POST_TRIGGER_COUNT > 0) ? $clog2(POST_TRIGGER_COUNT + 1) : 1;
  localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_OCCURRENCE - 1);
  localparam logic [PW-1:0] POST_LAST  = PW'(POST_TRIGGER_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [MW-1:0]           match_cnt_q, match_cnt_d;
  logic [PW-1:0]           post_cnt_q, post_cnt_d;
  logic                    trig_d;
  logic                    hit_s;
  logic [DATA_WIDTH-1:0]   capture_data_q;
  logic                    capture_enable_q;
  logic                    trigger_q;
  logic                    armed_q;
  logic                    done_q;

`ifdef TRACE_TRIGGER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  // An all-zero mask turns every valid event into a match.
  assign hit_s = event_valid &&
                 (((event_data ^ match_value) & match_mask) == {DATA_WIDTH{1'b0}});

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    post_cnt_d  = post_cnt_q;
    trig_d      = 1'b0;
`ifdef TRACE_TRIGGER_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          state_d     = ST_ARMED;
          match_cnt_d = {MW{1'b0}};
          post_cnt_d  = {PW{1'b0}};
`ifdef TRACE_TRIGGER_TIMEOUT_EN
          tmo_cnt_d   = {TW{1'b0}};
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_ARMED: begin
        if (hit_s) begin
          match_cnt_d = match_cnt_q + MW'(1);
        end else begin
          match_cnt_d = match_cnt_q;
        end
`ifdef TRACE_TRIGGER_TIMEOUT_EN
        if (tmo_cnt_q != TMO_MAX) begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end else begin
          tmo_cnt_d = tmo_cnt_q;
        end
`endif
        // The final match outranks a timeout expiring in the same cycle.
        if (hit_s && (match_cnt_q == MATCH_LAST)) begin
          if (POST_TRIGGER_COUNT == 0) begin
            state_d = ST_DONE;
            trig_d  = 1'b1;
          end else begin
            state_d = ST_POST;
          end
        end
`ifdef TRACE_TRIGGER_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          state_d = ST_DONE;
          trig_d  = 1'b1;
        end
`endif
        else begin
          state_d = ST_ARMED;
        end
      end
      ST_POST: begin
        if (event_valid) begin
          post_cnt_d = post_cnt_q + PW'(1);
          if (post_cnt_q == POST_LAST) begin
            state_d = ST_DONE;
            trig_d  = 1'b1;
          end else begin
            state_d = ST_POST;
          end
        end else begin
          state_d = ST_POST;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      match_cnt_q <= {MW{1'b0}};
      post_cnt_q  <= {PW{1'b0}};
`ifdef TRACE_TRIGGER_TIMEOUT_EN
      tmo_cnt_q   <= {TW{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      post_cnt_q  <= post_cnt_d;
`ifdef TRACE_TRIGGER_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  // Trigger is registered alongside capture_enable so the final event is stored with the pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      capture_data_q   <= {DATA_WIDTH{1'b0}};
      capture_enable_q <= 1'b0;
      trigger_q        <= 1'b0;
      armed_q          <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      capture_data_q   <= event_data;
      capture_enable_q <= event_valid && ((state_q == ST_ARMED) || (state_q == ST_POST));
      trigger_q        <= trig_d;
      armed_q          <= (state_d == ST_ARMED) || (state_d == ST_POST);
      done_q           <= (state_d == ST_DONE);
    end
  end

  assign capture_data   = capture_data_q;
  assign capture_enable = capture_enable_q;
  assign trigger        = trigger_q;
  assign armed          = armed_q;
  assign done           = done_q;

endmodule

// File: tb/tb_trace_trigger.sv
// Self-checking bench for trace_trigger: directed scenarios plus a randomized run against
// an abstract per-instance reference model (three parameterizations side by side).
module tb_trace_trigger;

`ifdef TRACE_TRIGGER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int MO  [3] = '{1, 3, 1};
  localparam int PTC [3] = '{16, 0, 16};
  localparam int TMO [3] = '{1024, 1024, 8};

  logic        clk;
  logic        rst_n;
  logic        arm;
  logic        ev_valid;
  logic [31:0] ev_data;
  logic [31:0] mval;
  logic [31:0] mmask;

  logic [31:0] cd [3];
  logic        ce [3];
  logic        tr [3];
  logic        ar [3];
  logic        dn [3];

  int ph [3];
  int mc [3];
  int pc [3];
  int tc [3];
  logic [31:0] e_cd [3];
  logic        e_ce [3];
  logic        e_tr [3];
  logic        e_ar [3];
  logic        e_dn [3];

  int n_vec;
  int n_err;

  trace_trigger u_dut0 (
    .clk(clk), .reset(rst_n), .arm(arm), .event_valid(ev_valid), .event_data(ev_data),
    .match_value(mval), .match_mask(mmask), .capture_data(cd[0]), .capture_enable(ce[0]),
    .trigger(tr[0]), .armed(ar[0]), .done(dn[0])
  );

  trace_trigger #(.MATCH_OCCURRENCE(3), .POST_TRIGGER_COUNT(0)) u_dut1 (
    .clk(clk), .reset(rst_n), .arm(arm), .event_valid(ev_valid), .event_data(ev_data),
    .match_value(mval), .match_mask(mmask), .capture_data(cd[1]), .capture_enable(ce[1]),
    .trigger(tr[1]), .armed(ar[1]), .done(dn[1])
  );

  trace_trigger #(.TIMEOUT_CYCLES(8)) u_dut2 (
    .clk(clk), .reset(rst_n), .arm(arm), .event_valid(ev_valid), .event_data(ev_data),
    .match_value(mval), .match_mask(mmask), .capture_data(cd[2]), .capture_enable(ce[2]),
    .trigger(tr[2]), .armed(ar[2]), .done(dn[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Phases: 0 idle, 1 waiting for matches, 2 collecting post events, 3 finished.
  function automatic void model_reset(input int k);
    ph[k] = 0; mc[k] = 0; pc[k] = 0; tc[k] = 0;
    e_cd[k] = 32'h0; e_ce[k] = 1'b0; e_tr[k] = 1'b0; e_ar[k] = 1'b0; e_dn[k] = 1'b0;
  endfunction

  function automatic void model_step(input int k);
    bit matched;
    if (!rst_n) begin
      model_reset(k);
      return;
    end
    matched = ev_valid && ((ev_data & mmask) == (mval & mmask));
    e_cd[k] = ev_data;
    e_ce[k] = ev_valid && (ph[k] == 1 || ph[k] == 2);
    e_tr[k] = 1'b0;
    if (ph[k] == 0 || ph[k] == 3) begin
      if (arm) begin
        ph[k] = 1; mc[k] = 0; pc[k] = 0; tc[k] = 0;
      end
    end else if (ph[k] == 1) begin
      tc[k] = tc[k] + 1;
      if (matched) mc[k] = mc[k] + 1;
      if (matched && mc[k] == MO[k]) begin
        if (PTC[k] == 0) begin ph[k] = 3; e_tr[k] = 1'b1; end
        else ph[k] = 2;
      end else if (TMO_EN && tc[k] >= TMO[k]) begin
        ph[k] = 3; e_tr[k] = 1'b1;
      end
    end else begin
      if (ev_valid) begin
        pc[k] = pc[k] + 1;
        if (pc[k] == PTC[k]) begin ph[k] = 3; e_tr[k] = 1'b1; end
      end
    end
    e_ar[k] = (ph[k] == 1 || ph[k] == 2);
    e_dn[k] = (ph[k] == 3);
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
  endtask

  task automatic do_reset();
    arm = 1'b0; ev_valid = 1'b0; ev_data = 32'h0;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) model_reset(k);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({cd[k], ce[k], tr[k], ar[k], dn[k]} !== 36'h0) begin
        n_err++;
        $display("FAIL reset_outputs inst%0d: got %h, expected 0", k, {cd[k], ce[k], tr[k], ar[k], dn[k]});
      end
    end
    rst_n = 1'b1;
    ev_valid = 1'b1; mmask = 32'h0; mval = 32'h0;
    for (int i = 0; i < 3; i++) begin
      ev_data = $urandom();
      tick();
    end
    n_vec++;
    if (ar[0] !== 1'b0 || ce[0] !== 1'b0 || dn[0] !== 1'b0) begin
      n_err++;
      $display("FAIL reset_needs_arm: got armed=%b ce=%b done=%b, expected 0 0 0", ar[0], ce[0], dn[0]);
    end
    ev_valid = 1'b0;
  endtask

  task automatic test_basic();
    int ce_n = 0, trig_n = 0, trig_at = 0;
    do_reset();
    mmask = 32'hFFFF_FFFF; mval = 32'h0000_1234;
    arm = 1'b1; tick(); arm = 1'b0;
    n_vec++;
    if (ar[0] !== 1'b1) begin n_err++; $display("FAIL basic_armed: got %b, expected 1", ar[0]); end
    for (int i = 0; i < 21; i++) begin
      ev_valid = 1'b1;
      ev_data = (i == 0) ? 32'h0000_1234 : $urandom();
      tick();
      if (i == 3) begin
        n_vec++;
        if (cd[0] !== ev_data) begin n_err++; $display("FAIL basic_capture_data: got %h, expected %h", cd[0], ev_data); end
      end
      if (ce[0] === 1'b1) ce_n++;
      if (tr[0] === 1'b1) begin trig_n++; trig_at = ce_n; end
    end
    ev_valid = 1'b0;
    n_vec++;
    if (ce_n != 17) begin n_err++; $display("FAIL basic_capture_count: got %0d, expected 17", ce_n); end
    n_vec++;
    if (trig_n != 1 || trig_at != 17) begin
      n_err++; $display("FAIL basic_trigger: got %0d pulses at capture %0d, expected 1 at 17", trig_n, trig_at);
    end
    n_vec++;
    if (dn[0] !== 1'b1 || ar[0] !== 1'b0) begin
      n_err++; $display("FAIL basic_done: got done=%b armed=%b, expected 1 0", dn[0], ar[0]);
    end
  endtask

  task automatic test_occurrence();
    logic [31:0] seq [6] = '{32'hA5, 32'h00, 32'hA5, 32'h00, 32'hA5, 32'h00};
    int first = -1, trig_n = 0;
    logic ce_at = 1'b0;
    do_reset();
    mmask = 32'hFFFF_FFFF; mval = 32'h0000_00A5;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ev_valid = 1'b1; ev_data = seq[i];
      tick();
      if (tr[1] === 1'b1) begin
        trig_n++;
        if (first < 0) begin first = i; ce_at = ce[1]; end
      end
    end
    ev_valid = 1'b0;
    n_vec++;
    if (first != 4 || trig_n != 1 || ce_at !== 1'b1) begin
      n_err++; $display("FAIL occurrence_trigger: got first=%0d pulses=%0d ce=%b, expected 4 1 1", first, trig_n, ce_at);
    end
    n_vec++;
    if (dn[1] !== 1'b1) begin n_err++; $display("FAIL occurrence_done: got %b, expected 1", dn[1]); end
  endtask

  task automatic test_mask();
    logic [31:0] seq [5] = '{32'h0000_0043, 32'hDEAD_0042, 32'hDEAD_0042, 32'h0000_0043, 32'hDEAD_0042};
    int first = -1;
    do_reset();
    mmask = 32'h0000_00FF; mval = 32'h0000_0042;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ev_valid = 1'b1; ev_data = seq[i];
      tick();
      if (tr[1] === 1'b1 && first < 0) first = i;
    end
    ev_valid = 1'b0;
    n_vec++;
    if (first != 4) begin n_err++; $display("FAIL mask_match: got trigger at %0d, expected 4", first); end
  endtask

  task automatic test_reset_mid_post();
    int first = -1, ce_n = 0;
    do_reset();
    mmask = 32'hFFFF_FFFF; mval = 32'h0000_1234;
    arm = 1'b1; tick(); arm = 1'b0;
    ev_valid = 1'b1; ev_data = 32'h0000_1234; tick();
    for (int i = 0; i < 5; i++) begin ev_data = $urandom(); tick(); end
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) model_reset(k);
    n_vec++;
    if ({cd[0], ce[0], tr[0], ar[0], dn[0]} !== 36'h0) begin
      n_err++; $display("FAIL midpost_reset_now: got %h, expected 0", {cd[0], ce[0], tr[0], ar[0], dn[0]});
    end
    tick();
    n_vec++;
    if (tr[0] !== 1'b0 || ce[0] !== 1'b0) begin
      n_err++; $display("FAIL midpost_no_trigger: got trig=%b ce=%b, expected 0 0", tr[0], ce[0]);
    end
    rst_n = 1'b1;
    ev_data = 32'h0000_1234;
    for (int i = 0; i < 3; i++) begin tick(); if (ce[0] === 1'b1 || ar[0] === 1'b1) ce_n++; end
    n_vec++;
    if (ce_n != 0) begin n_err++; $display("FAIL midpost_need_arm: got %0d active cycles, expected 0", ce_n); end
    ev_valid = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ev_valid = 1'b1; ev_data = (i == 0) ? 32'h0000_1234 : $urandom();
      tick();
      if (tr[0] === 1'b1 && first < 0) first = i;
    end
    ev_valid = 1'b0;
    n_vec++;
    if (first != 16) begin n_err++; $display("FAIL midpost_rearm_window: got trigger at %0d, expected 16", first); end
  endtask

  task automatic test_rearm();
    int first = -1, second = -1;
    do_reset();
    mmask = 32'hFFFF_FFFF; mval = 32'h0000_1234;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ev_valid = 1'b1; ev_data = (i == 0) ? 32'h0000_1234 : 32'h0000_1234 + i;
      arm = (i == 4);
      tick();
      if (tr[0] === 1'b1 && first < 0) first = i;
    end
    n_vec++;
    if (first != 16) begin n_err++; $display("FAIL rearm_post_ignored: got trigger at %0d, expected 16", first); end
    arm = 1'b1; ev_valid = 1'b1; ev_data = 32'h0000_1234;
    tick();
    arm = 1'b0;
    n_vec++;
    if (ar[0] !== 1'b1 || ce[0] !== 1'b0 || dn[0] !== 1'b0) begin
      n_err++; $display("FAIL rearm_from_done: got armed=%b ce=%b done=%b, expected 1 0 0", ar[0], ce[0], dn[0]);
    end
    for (int i = 0; i < 20; i++) begin
      ev_data = (i == 0) ? 32'h0000_1234 : $urandom();
      tick();
      if (tr[0] === 1'b1 && second < 0) second = i;
    end
    ev_valid = 1'b0;
    n_vec++;
    if (second != 16) begin n_err++; $display("FAIL rearm_new_window: got trigger at %0d, expected 16", second); end
  endtask

  task automatic test_timeout();
    int first = -1, trig_n = 0;
    do_reset();
    mmask = 32'hFFFF_FFFF; mval = 32'h0000_1234;
    ev_valid = 1'b1; ev_data = 32'h0;
    arm = 1'b1; tick(); arm = 1'b0;
    if (TMO_EN) begin
      for (int i = 1; i <= 12; i++) begin
        tick();
        if (tr[2] === 1'b1 && first < 0) first = i;
      end
      n_vec++;
      if (first != 8 || dn[2] !== 1'b1) begin
        n_err++; $display("FAIL timeout_fire: got trigger at %0d done=%b, expected 8 1", first, dn[2]);
      end
    end else begin
      for (int i = 1; i <= 1000; i++) begin
        tick();
        if (tr[2] === 1'b1) trig_n++;
      end
      n_vec++;
      if (trig_n != 0 || ar[2] !== 1'b1) begin
        n_err++; $display("FAIL timeout_absent: got %0d pulses armed=%b, expected 0 1", trig_n, ar[2]);
      end
    end
    ev_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [35:0] got, exp;
    do_reset();
    mval = 32'h1; mmask = 32'hFFFF_FFFF;
    for (int n = 0; n < 4000; n++) begin
      if (n % 50 == 0) begin
        case ($urandom_range(0, 2))
          0: mmask = 32'h0;
          1: mmask = 32'h0000_0003;
          default: mmask = 32'hFFFF_FFFF;
        endcase
        mval = $urandom_range(0, 3);
      end
      rst_n = ($urandom_range(0, 199) != 0);
      arm = ($urandom_range(0, 11) == 0);
      ev_valid = ($urandom_range(0, 3) != 0);
      ev_data = (mmask == 32'hFFFF_FFFF) ? 32'($urandom_range(0, 3)) : {$urandom_range(0, 65535)} << 16 | 32'($urandom_range(0, 3));
      tick();
      for (int k = 0; k < 3; k++) begin
        got = {cd[k], ce[k], tr[k], ar[k], dn[k]};
        exp = {e_cd[k], e_ce[k], e_tr[k], e_ar[k], e_dn[k]};
        n_vec++;
        if (got !== exp) begin
          n_err++; $display("FAIL random inst%0d cycle %0d: got %h, expected %h", k, n, got, exp);
        end
      end
    end
    rst_n = 1'b1; arm = 1'b0; ev_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; arm = 1'b0; ev_valid = 1'b0; ev_data = 32'h0; mval = 32'h0; mmask = 32'h0;
    for (int k = 0; k < 3; k++) model_reset(k);
    #3;
    test_reset();
    test_basic();
    test_occurrence();
    test_mask();
    test_reset_mid_post();
    test_rearm();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
